// File: rtl/neuron_classifier_if.sv
// Sample-in / result-out stream bundle for neuron_classifier.
// master = sample producer and result consumer; slave = the classifier.
interface neuron_classifier_if #(
    parameter int XW = 7,
    parameter int AW = 23
);
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x1_in;
    logic [XW-1:0] x2_in;
    logic [1:0]    t_in;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] y_out;
    logic [1:0]    class_out;

    modport master (
        output in_valid, x1_in, x2_in, t_in, out_ready,
        input  in_ready, out_valid, y_out, class_out
    );
    modport slave (
        input  in_valid, x1_in, x2_in, t_in, out_ready,
        output in_ready, out_valid, y_out, class_out
    );
endinterface

// File: rtl/neuron_classifier.sv
// Two-input perceptron inference: 2-stage multiply/accumulate pipeline over a batch of n samples.
// Optional NEURON_ERRCNT_EN carries the expected class and counts misclassifications on err_cnt.
module neuron_classifier #(
    parameter int XW = 7,
    parameter int WW = 14,
    parameter int NW = 20,
    parameter int AW = 23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_w,
    input  logic [WW-1:0] w1_in,
    input  logic [WW-1:0] w2_in,
    input  logic [WW-1:0] b_in,
    input  logic          start,
    input  logic [NW-1:0] n_in,
    neuron_classifier_if.slave s,
    output logic          busy,
    output logic          done
`ifdef NEURON_ERRCNT_EN
    ,
    output logic [NW-1:0] err_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, nextState;

    logic signed [WW-1:0] w1, w2, b;
    logic [NW-1:0]        n, acceptCnt, emitCnt;
    logic [2:1]           vldPipe;
    logic signed [AW-1:0] p1, p2, y, sum;
    logic signed [AW-1:0] x1e, x2e, w1e, w2e, bExt;
    logic [1:0]           cls;
    logic adv, accept, emit, startOk, ldOk;

    assign startOk = start && (state != RUN);
    assign ldOk    = ld_w && (state != RUN);

    assign adv        = !vldPipe[2] || s.out_ready;
    assign s.in_ready = (state == RUN) && (acceptCnt < n) && (!vldPipe[1] || adv);
    assign accept     = s.in_valid && s.in_ready;
    assign emit       = vldPipe[2] && s.out_ready;

    assign x1e  = AW'($signed(s.x1_in));
    assign x2e  = AW'($signed(s.x2_in));
    assign w1e  = AW'(w1);
    assign w2e  = AW'(w2);
    assign bExt = AW'(b);
    assign sum  = p1 + p2 + bExt;

    assign s.out_valid = vldPipe[2];
    assign s.y_out     = y;
    assign s.class_out = cls;
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // DONE is entered together with the final handshake so done follows the last emit directly
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: if (start) nextState = (n_in == '0) ? DONE : RUN;
            RUN: if (emitCnt == n || (emit && (emitCnt + NW'(1)) == n)) nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w1 <= '0; w2 <= '0; b <= '0;
            n <= '0; acceptCnt <= '0; emitCnt <= '0;
            vldPipe <= '0;
            p1 <= '0; p2 <= '0; y <= '0; cls <= 2'b00;
        end else begin
            if (ldOk) begin
                w1 <= w1_in; w2 <= w2_in; b <= b_in;
            end
            if (startOk) begin
                n <= n_in; acceptCnt <= '0; emitCnt <= '0;
            end else begin
                if (accept) acceptCnt <= acceptCnt + NW'(1);
                if (emit)   emitCnt   <= emitCnt + NW'(1);
            end
            // stage 1 may fill while stalled if it was empty
            if (accept) begin
                p1 <= x1e * w1e;
                p2 <= x2e * w2e;
                vldPipe[1] <= 1'b1;
            end else if (adv) begin
                vldPipe[1] <= 1'b0;
            end
            if (adv) begin
                vldPipe[2] <= vldPipe[1];
                if (vldPipe[1]) begin
                    y   <= sum;
                    cls <= {sum[AW-1], 1'b1};
                end
            end
        end
    end

`ifdef NEURON_ERRCNT_EN
    logic [1:0] t1, t2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1 <= 2'b00; t2 <= 2'b00; err_cnt <= '0;
        end else begin
            if (accept) t1 <= s.t_in;
            if (adv && vldPipe[1]) t2 <= t1;
            if (startOk) err_cnt <= '0;
            else if (emit && cls != t2) err_cnt <= err_cnt + NW'(1);
        end
    end
`else
    logic unusedT;
    assign unusedT = ^s.t_in;
`endif
endmodule

// File: tb/tb_neuron_classifier.sv
// Directed + randomized bench for neuron_classifier against an arithmetic reference model.
module tb_neuron_classifier;
    localparam int XW = 7, WW = 14, NW = 20, AW = 23;

    logic clk = 1'b0, rst = 1'b1, ld_w = 1'b0, start = 1'b0;
    logic [WW-1:0] w1_in = '0, w2_in = '0, b_in = '0;
    logic [NW-1:0] n_in = '0;
    logic busy, done;
`ifdef NEURON_ERRCNT_EN
    logic [NW-1:0] err_cnt;
`endif

    neuron_classifier_if #(.XW(XW), .AW(AW)) bus();

    neuron_classifier #(.XW(XW), .WW(WW), .NW(NW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .ld_w(ld_w), .w1_in(w1_in), .w2_in(w2_in), .b_in(b_in),
        .start(start), .n_in(n_in), .s(bus), .busy(busy), .done(done)
`ifdef NEURON_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nTot = 0, nPass = 0;
    int mw1 = 0, mw2 = 0, mb = 0, mErr = 0;
    int expY[$], expT[$];
    int sx1[$], sx2[$], st[$];
    int cyc = 0, emitted = 0, accepted = 0, firstAcc = -1, firstOut = -1;
    bit lastAcc = 0, holdPend = 0;
    int holdY = 0;

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        nTot++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // one clock: sample at negedge+1, score outputs, record accepts into the model
    task automatic step();
        int ey, et, x1, x2;
        #1;
        lastAcc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && firstOut < 0) firstOut = cyc;
        if (holdPend) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_y", $signed(bus.y_out), holdY);
            holdPend = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("result_expected", expY.size() > 0, 1);
            if (expY.size() > 0) begin
                ey = expY.pop_front();
                et = expT.pop_front();
                chk("y", $signed(bus.y_out), ey);
                chk("class", bus.class_out, (ey >= 0) ? 1 : 3);
                if (((ey >= 0) ? 1 : 3) != et) mErr++;
            end
            emitted++;
        end else if (bus.out_valid) begin
            holdPend = 1;
            holdY = $signed(bus.y_out);
        end
        if (lastAcc) begin
            x1 = $signed(bus.x1_in);
            x2 = $signed(bus.x2_in);
            expY.push_back(x1 * mw1 + x2 * mw2 + mb);
            expT.push_back(int'(bus.t_in));
            accepted++;
            if (firstAcc < 0) firstAcc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // only issued while the bench knows the DUT is idle, so the model follows ld_w
    task automatic cmd(bit ldw, int a, int bb, int c, bit stt, int n);
        ld_w = ldw; w1_in = WW'(a); w2_in = WW'(bb); b_in = WW'(c);
        start = stt; n_in = NW'(n);
        if (ldw) begin mw1 = a; mw2 = bb; mb = c; end
        if (stt) mErr = 0;
        step();
        ld_w = 0; start = 0;
    endtask

    // mode 0: out_ready=1; 1: stall 5 cycles; 2: random out_ready; 3: junk commands in RUN
    task automatic stream(int n, int mode, int budget);
        int k = 0, idx = 0;
        emitted = 0; accepted = 0; firstAcc = -1; firstOut = -1;
        while (emitted < n && k < budget) begin
            bus.in_valid = 1'b1;
            bus.x1_in = XW'(sx1[(idx < n) ? idx : 0]);
            bus.x2_in = XW'(sx2[(idx < n) ? idx : 0]);
            bus.t_in  = 2'(st[(idx < n) ? idx : 0]);
            bus.out_ready = (mode == 1) ? (k >= 5) : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 3 && k == 1) begin
                ld_w = 1; w1_in = WW'(100); w2_in = WW'(100); b_in = WW'(100);
                start = 1; n_in = NW'(1);
            end else begin
                ld_w = 0; start = 0;
            end
            step();
            if (lastAcc) idx++;
            if (mode == 1 && k == 4) begin
                chk("bp_accepted", accepted, 2);
                chk("bp_in_ready", bus.in_ready, 0);
                chk("bp_y_held", $signed(bus.y_out), expY[0]);
            end
            k++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; ld_w = 0; start = 0;
        chk("emit_count", emitted, n);
        chk("accept_count", accepted, n);
        chk("model_drained", expY.size(), 0);
        chk("done_after_last", done, 1);
        chk("busy_after_last", busy, 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.x1_in = '0; bus.x2_in = '0; bus.t_in = '0; bus.out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", $signed(bus.y_out), 0);
        chk("rst_class", bus.class_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // basic, weights and start in the same cycle
        sx1 = '{4, 1, 1}; sx2 = '{5, 5, 2}; st = '{1, 1, 3};
        cmd(1, 3, -2, 1, 1, 3);
        chk("basic_busy", busy, 1);
        stream(3, 0, 50);
        chk("latency", firstOut - firstAcc, 2);
`ifdef NEURON_ERRCNT_EN
        chk("err_cnt_basic", err_cnt, mErr);
`endif

        // back-pressure
        cmd(0, 0, 0, 0, 1, 3);
        stream(3, 1, 50);

        // extremes
        sx1 = '{-64, 63}; sx2 = '{-64, -64}; st = '{1, 1};
        cmd(1, -8192, -8192, 8191, 1, 2);
        stream(2, 0, 50);

        // random weights, samples and back-pressure
        sx1.delete(); sx2.delete(); st.delete();
        for (int i = 0; i < 20; i++) begin
            sx1.push_back(int'($urandom_range(0, 127)) - 64);
            sx2.push_back(int'($urandom_range(0, 127)) - 64);
            st.push_back($urandom_range(0, 1) ? 1 : 3);
        end
        cmd(1, int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
            int'($urandom_range(0, 16383)) - 8192, 1, 20);
        stream(20, 2, 400);
`ifdef NEURON_ERRCNT_EN
        chk("err_cnt_random", err_cnt, mErr);
`endif

        // ld_w/start during RUN must be ignored
        sx1 = '{4, 1, 1, -7}; sx2 = '{5, 5, 2, 9}; st = '{1, 1, 1, 1};
        cmd(1, 3, -2, 1, 1, 4);
        stream(4, 3, 50);

        // async reset mid-batch
        cmd(0, 0, 0, 0, 1, 4);
        bus.in_valid = 1; bus.x1_in = XW'(2); bus.x2_in = XW'(3); bus.out_ready = 1;
        step(); step();
        bus.in_valid = 0;
        chk("pre_rst_out_valid", bus.out_valid, 1);
        chk("pre_rst_busy", busy, 1);
        #3 rst = 1;
        #1;
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        @(negedge clk);
        rst = 0;
        expY.delete(); expT.delete(); holdPend = 0;
        mw1 = 0; mw2 = 0; mb = 0;
        @(negedge clk);

        // empty batch from IDLE
        cmd(0, 0, 0, 0, 1, 0);
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        accepted = 0;
        bus.in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 0;
        chk("empty_accepts", accepted, 0);

        // weights were cleared by reset
        sx1 = '{5}; sx2 = '{7}; st = '{1};
        cmd(0, 0, 0, 0, 1, 1);
        stream(1, 0, 50);

        // misclassification counter
        sx1 = '{4, 1, 1}; sx2 = '{5, 5, 2}; st = '{1, 1, 3};
        cmd(1, 3, -2, 1, 1, 3);
`ifdef NEURON_ERRCNT_EN
        chk("err_cnt_cleared", err_cnt, 0);
`endif
        stream(3, 0, 50);
`ifdef NEURON_ERRCNT_EN
        chk("err_cnt_final", err_cnt, mErr);
        step();
        chk("err_cnt_hold", err_cnt, mErr);
`endif

        $display("%0d/%0d checks passed", nPass, nTot);
        $finish;
    end
endmodule
